// File: rtl/audio_pkg.sv
// Shared audio definitions: note half-periods (synth ticks), tone-meter states, default tick divider.
package audio_pkg;

    localparam int unsigned TICK_DIV_DEF = 2048;

    localparam int unsigned NOTE_B1 = 100;
    localparam int unsigned NOTE_C2 = 94;
    localparam int unsigned NOTE_D2 = 84;
    localparam int unsigned NOTE_E2 = 75;
    localparam int unsigned NOTE_F2 = 71;
    localparam int unsigned NOTE_G2 = 63;
    localparam int unsigned NOTE_A2 = 56;
    localparam int unsigned NOTE_B2 = 50;
    localparam int unsigned NOTE_C3 = 47;
    localparam int unsigned NOTE_D3 = 42;
    localparam int unsigned NOTE_E3 = 37;
    localparam int unsigned NOTE_F3 = 35;
    localparam int unsigned NOTE_G3 = 31;
    localparam int unsigned NOTE_A3 = 28;

    typedef enum logic [1:0] {
        TM_IDLE    = 2'd0,
        TM_ACQUIRE = 2'd1,
        TM_LOCKED  = 2'd2
    } tm_state_t;

endpackage

// File: rtl/audio_tone_meter_if.sv
// Audio line in, recovered tone report out; master side is the meter.
interface audio_tone_meter_if #(
    parameter int unsigned HP_W = 7
);
    logic            audio_in;
    logic [HP_W-1:0] hp_out;
    logic            active;
    logic            note_strobe;
    logic            silence_strobe;

    modport master (
        input  audio_in,
        output hp_out,
        output active,
        output note_strobe,
        output silence_strobe
    );

    modport slave (
        output audio_in,
        input  hp_out,
        input  active,
        input  note_strobe,
        input  silence_strobe
    );
endinterface

// File: rtl/audio_edge_sync.sv
// Two-flop synchronizer plus delay flop; edge_c flags either polarity of a settled transition.
module audio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic audio_in,
    output logic edge_c
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= audio_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign edge_c = sync2_q ^ dly_q;

endmodule

// File: rtl/audio_tone_meter.sv
// Measures square-wave half-periods in synth ticks, locks onto a stable tone and
// reports each newly locked note and each drop to silence.
module audio_tone_meter
    import audio_pkg::*;
#(
    parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
    parameter int unsigned HP_W          = 7,
    parameter int unsigned SILENCE_TICKS = 120,
    parameter int unsigned MATCH_COUNT   = 2,
    parameter int unsigned TOL           = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    audio_tone_meter_if.master bus
);

    localparam int unsigned     PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [HP_W-1:0] CNT_MAX    = '1;
    localparam logic [HP_W-1:0] SIL_CNT    = HP_W'(SILENCE_TICKS);
    localparam logic [HP_W-1:0] TOL_V      = HP_W'(TOL);
    localparam logic [2:0]      MATCH_LOCK = 3'(MATCH_COUNT);

    logic             edge_c;
    logic             tick_c;
    logic [PRE_W-1:0] pre_q;
    logic [HP_W-1:0]  cnt_q;
    logic [HP_W:0]    meas_sum_c;
    logic [HP_W-1:0]  meas_c;
    logic             within_prev_c;
    logic             within_hp_c;
    logic [2:0]       match_new_c;

    tm_state_t        state_q, state_d;
    logic [HP_W-1:0]  prev_q, prev_d;
    logic [2:0]       match_q, match_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic             note_q, note_d;
    logic             silence_q, silence_d;
    logic             active_q;

    function automatic logic [HP_W-1:0] abs_diff(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    audio_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .audio_in (bus.audio_in),
        .edge_c   (edge_c)
    );

    // Free-running tick prescaler
    assign tick_c = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pre_q <= '0;
        else if (tick_c) pre_q <= '0;
        else             pre_q <= pre_q + PRE_W'(1);
    end

    // Saturating interval counter; a tick coincident with an edge closes the old interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cnt_q <= '0;
        else if (edge_c)                        cnt_q <= '0;
        else if (tick_c && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + HP_W'(1);
    end

    assign meas_sum_c    = {1'b0, cnt_q} + {{HP_W{1'b0}}, tick_c};
    assign meas_c        = meas_sum_c[HP_W] ? CNT_MAX : meas_sum_c[HP_W-1:0];
    assign within_prev_c = (abs_diff(meas_c, prev_q) <= TOL_V);
    assign within_hp_c   = (abs_diff(meas_c, hp_q) <= TOL_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TM_IDLE;
            prev_q    <= '0;
            match_q   <= '0;
            hp_q      <= '0;
            note_q    <= 1'b0;
            silence_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            hp_q      <= hp_d;
            note_q    <= note_d;
            silence_q <= silence_d;
            active_q  <= (state_d == TM_LOCKED);
        end
    end

    // Edge wins over a coincident silence timeout
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_d     = match_q;
        hp_d        = hp_q;
        note_d      = 1'b0;
        silence_d   = 1'b0;
        match_new_c = '0;

        if (edge_c) begin
            unique case (state_q)
                TM_IDLE: begin
                    state_d = TM_ACQUIRE;
                    match_d = '0;
                end
                TM_ACQUIRE: begin
                    if (meas_c == '0)                          match_new_c = '0;
                    else if ((match_q == '0) || !within_prev_c) match_new_c = 3'd1;
                    else                                       match_new_c = match_q + 3'd1;
                    prev_d  = meas_c;
                    match_d = match_new_c;
                    if (match_new_c == MATCH_LOCK) begin
                        state_d = TM_LOCKED;
                        hp_d    = meas_c;
                        note_d  = 1'b1;
                    end
                end
                TM_LOCKED: begin
                    if (!(within_hp_c && (meas_c != '0))) begin
                        state_d = TM_ACQUIRE;
                        prev_d  = meas_c;
                        match_d = 3'd1;
                        if ((MATCH_LOCK == 3'd1) && (meas_c != '0)) begin
                            state_d = TM_LOCKED;
                            hp_d    = meas_c;
                            note_d  = 1'b1;
                        end
                    end
                end
                default: state_d = TM_IDLE;
            endcase
        end else if (cnt_q >= SIL_CNT) begin
            state_d   = TM_IDLE;
            match_d   = '0;
            silence_d = (state_q == TM_LOCKED);
        end
    end

    assign bus.hp_out         = hp_q;
    assign bus.active         = active_q;
    assign bus.note_strobe    = note_q;
    assign bus.silence_strobe = silence_q;

endmodule

// File: tb/tb_audio_tone_meter.sv
// Randomized square-wave stimulus against a tick-arithmetic reference model; a monitor
// pops expected strobe events from a queue whenever the meter strobes.
module tb_audio_tone_meter;
    import audio_pkg::*;

    localparam int unsigned TD   = 8;
    localparam int unsigned HPW  = 7;
    localparam int unsigned SIL  = 120;
    localparam int unsigned MC   = 2;
    localparam int          TOLR = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    audio_tone_meter_if #(.HP_W(HPW)) bus ();

    audio_tone_meter #(
        .TICK_DIV      (TD),
        .HP_W          (HPW),
        .SILENCE_TICKS (SIL),
        .MATCH_COUNT   (MC),
        .TOL           (TOLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 1 = note, 2 = silence
        int hp;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int unsigned kcyc;

    int unsigned notes[14] = '{NOTE_B1, NOTE_C2, NOTE_D2, NOTE_E2, NOTE_F2, NOTE_G2, NOTE_A2,
                               NOTE_B2, NOTE_C3, NOTE_D3, NOTE_E3, NOTE_F3, NOTE_G3, NOTE_A3};

    // Reference model: state of the tone tracker and clk index of the last registered edge
    int m_state;  // 0 idle, 1 acquiring, 2 locked
    int m_prev;
    int m_match;
    int m_hp;
    int unsigned m_last;

    // Posedges since reset release; prescaler ticks land on multiples of TD
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) kcyc <= 0;
        else        kcyc <= kcyc + 1;
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_match = 0; m_hp = 0; m_last = 0;
    endtask

    // Ticks in (last edge, e], saturated to the counter range
    function automatic int meas_of(input int unsigned e);
        int unsigned t;
        t = e / TD - m_last / TD;
        return (t > 127) ? 127 : int'(t);
    endfunction

    // Silence: 120th tick after the last edge, seen by the tracker one clk later
    task automatic model_advance(input int unsigned until_k);
        int unsigned s1;
        if (m_state != 0) begin
            s1 = TD * (m_last / TD + SIL) + 1;
            if (s1 <= until_k) begin
                if (m_state == 2) q.push_back('{kind: 2, hp: m_hp, cyc: int'(s1)});
                m_state = 0;
                m_match = 0;
            end
        end
    endtask

    task automatic model_edge(input int unsigned e);
        int meas;
        if (m_state == 0) begin
            m_state = 1; m_match = 0; m_last = e;
            return;
        end
        meas = meas_of(e);
        m_last = e;
        if (m_state == 1) begin
            if (meas == 0)                                  m_match = 0;
            else if (m_match == 0 || absd(meas, m_prev) > TOLR) m_match = 1;
            else                                            m_match = m_match + 1;
            m_prev = meas;
            if (m_match == int'(MC)) begin
                m_state = 2;
                m_hp = meas;
                q.push_back('{kind: 1, hp: meas, cyc: int'(e)});
            end
        end else if (meas == 0 || absd(meas, m_hp) > TOLR) begin
            m_state = 1; m_prev = meas; m_match = 1;
        end
    endtask

    // Called at a negedge: toggle the line gap clk from now; the edge registers 3 clk later
    task automatic issue_edge(input int unsigned gap);
        int unsigned k0;
        int sa, sh;
        sa = (m_state == 2) ? 1 : 0;
        sh = m_hp;
        k0 = kcyc + gap;
        model_advance(k0 + 2);
        model_edge(k0 + 3);
        for (int i = 1; i <= int'(gap); i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("active", int'(bus.active), sa);
                check("hp_out", int'(bus.hp_out), sh);
            end
        end
        bus.audio_in = ~bus.audio_in;
    endtask

    task automatic hold(input int unsigned cycles);
        model_advance(kcyc + cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic play(input int unsigned hp, input int unsigned n, input bit jit, input int unsigned off);
        for (int i = 0; i < int'(n); i++)
            issue_edge((hp + (jit ? $urandom_range(0, 1) : 0)) * TD + ((i == 0) ? off : 0));
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (rst_n && (bus.note_strobe || bus.silence_strobe)) begin
            check("strobe_overlap", int'(bus.note_strobe & bus.silence_strobe), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: note=%0b silence=%0b hp_out=%0d cycle=%0d, none expected",
                         bus.note_strobe, bus.silence_strobe, bus.hp_out, kcyc);
            end else begin
                mon_e = q.pop_front();
                check("strobe_kind", bus.note_strobe ? 1 : 2, mon_e.kind);
                check("strobe_cycle", int'(kcyc), mon_e.cyc);
                check("strobe_hp", int'(bus.hp_out), mon_e.hp);
                check("strobe_active", int'(bus.active), (mon_e.kind == 1) ? 1 : 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hp;
        bus.audio_in = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_hp_out", int'(bus.hp_out), 0);
        check("rst_active", int'(bus.active), 0);
        check("rst_note", int'(bus.note_strobe), 0);
        check("rst_silence", int'(bus.silence_strobe), 0);
        rst_n = 1'b1;

        // Steady tone, retune while locked, tolerated jitter
        play(47, 23, 1'b0, 0);
        play(62, 4, 1'b0, 0);
        for (int i = 0; i < 8; i++) issue_edge(((i % 2 == 0) ? 56 : 55) * TD);

        // Silence after a lock, then relock
        play(28, 5, 1'b0, 0);
        hold(1000);
        check("silence_active", int'(bus.active), 0);
        check("silence_hp_hold", int'(bus.hp_out), 28);
        play(28, 4, 1'b0, 0);

        // Glitch pair inside a locked tone
        hp = notes[$urandom_range(0, 13)];
        play(hp, 4, 1'b0, 0);
        issue_edge((hp / 2) * TD);
        issue_edge(5);
        play(hp, 4, 1'b0, 0);

        // Random note segments with random phase, jitter and occasional silence
        for (int s = 0; s < 6; s++) begin
            play(notes[$urandom_range(0, 13)], $urandom_range(2, 6), 1'($urandom_range(0, 1)),
                 $urandom_range(0, TD - 1));
            if (s % 3 == 2) hold(1000);
        end

        // Reset while locked at the lowest note
        play(100, 4, 1'b0, 0);
        repeat (8) @(negedge clk);
        check("prereset_active", int'(bus.active), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_hp_out", int'(bus.hp_out), 0);
        check("midrst_active", int'(bus.active), 0);
        check("midrst_note", int'(bus.note_strobe), 0);
        check("midrst_silence", int'(bus.silence_strobe), 0);
        q.delete();
        model_reset();
        bus.audio_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        play(100, 3, 1'b0, 0);
        repeat (6) @(negedge clk);
        check("relock_active", int'(bus.active), 1);
        check("relock_hp", int'(bus.hp_out), 100);

        repeat (20) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
